// File: rtl/mmio_timer.sv
`default_nettype none
// ============================================================================
// Module      : mmio_timer
// Description : Memory-mapped countdown timer on the CPU data-memory bus.
//               One-shot and auto-reload modes with a maskable interrupt.
//               Register map (byte offsets from BASE):
//                 0x0 CTRL   (RW) [0] EN, [2:1] MODE, [3] IM
//                 0x4 PRESET (RW) reload value
//                 0x8 COUNT  (RO) current count
//                 0xC reserved (reads 0, writes ignored)
// Ports       : clk   - clock, rising edge
//               rst   - asynchronous active-high reset
//               addr  - CPU byte address (ALU output)
//               we    - CPU memory write strobe
//               wdata - CPU store data
//               rdata - combinational read data (0 when not hit)
//               hit   - combinational window decode
//               irq   - registered interrupt request
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_timer #(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        irq
);

    localparam logic [1:0] c_OFF_CTRL   = 2'd0;
    localparam logic [1:0] c_OFF_PRESET = 2'd1;
    localparam logic [1:0] c_OFF_COUNT  = 2'd2;
    localparam logic [1:0] c_MODE_AUTO  = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    state_t      r_state;
    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_pend;
    logic        r_irq;

    logic        w_hit;
    logic [1:0]  w_off;
    logic        w_ctrl_wr;
    logic        w_preset_wr;
    logic        w_en;
    logic        w_auto;
    logic        w_enter_int;
    logic [3:0]  w_ctrl_next;
    logic        w_pend_next;
    logic        w_irq_next;
    logic        w_unused_addr;

    // Byte lane bits play no part in decode.
    assign w_unused_addr = ^addr[1:0];

    assign w_hit       = (addr[31:4] == BASE[31:4]);
    assign w_off       = addr[3:2];
    assign w_ctrl_wr   = we && w_hit && (w_off == c_OFF_CTRL);
    assign w_preset_wr = we && w_hit && (w_off == c_OFF_PRESET);

    assign w_en   = r_ctrl[0];
    assign w_auto = (r_ctrl[2:1] == c_MODE_AUTO);

    // Final count tick: COUNT of 1 or 0 (PRESET=0 behaves as 1).
    assign w_enter_int = (r_state == ST_CNT) && w_en && (r_count <= 32'd1);

    // CPU write to CTRL takes priority over the one-shot EN auto-clear.
    always_comb begin
        w_ctrl_next = r_ctrl;
        if (w_ctrl_wr) begin
            w_ctrl_next = wdata[3:0];
        end else if ((r_state == ST_INT) && !w_auto) begin
            w_ctrl_next = {r_ctrl[3:1], 1'b0};
        end
    end

    // Pending flag is only meaningful in one-shot mode; set beats clear.
    assign w_pend_next = (w_enter_int && !w_auto) ||
                         (r_pend && !(w_ctrl_wr || w_preset_wr));

    // irq is computed from next-state values so it rises on the same edge
    // that enters INT rather than one cycle later.
    always_comb begin
        w_irq_next = 1'b0;
        if (w_ctrl_next[2:1] == c_MODE_AUTO) begin
            w_irq_next = w_enter_int && w_ctrl_next[3];
        end else begin
            w_irq_next = w_pend_next && w_ctrl_next[3];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ctrl   <= 4'd0;
            r_preset <= 32'd0;
            r_count  <= 32'd0;
            r_pend   <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_ctrl <= w_ctrl_next;
            r_pend <= w_pend_next;
            r_irq  <= w_irq_next;
            if (w_preset_wr) begin
                r_preset <= wdata;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_en) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_count <= r_preset;
                    r_state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!w_en) begin
                        r_state <= ST_IDLE;
                    end else if (r_count > 32'd1) begin
                        r_count <= r_count - 32'd1;
                    end else begin
                        r_count <= 32'd0;
                        r_state <= ST_INT;
                    end
                end
                ST_INT: begin
                    if (w_auto) begin
                        r_state <= ST_LOAD;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (w_hit) begin
            case (w_off)
                c_OFF_CTRL:   rdata = {28'd0, r_ctrl};
                c_OFF_PRESET: rdata = r_preset;
                c_OFF_COUNT:  rdata = r_count;
                default:      rdata = 32'd0;
            endcase
        end
    end

    assign hit = w_hit;
    assign irq = r_irq;

endmodule
`default_nettype wire
